// File: rtl/gcm_block_sequencer.sv
// Multi-block job sequencer in front of the gcm_aes core: setup, AAD stream, PT/CT stream, tag return.
// Optional build macro GCM_BYTE_SWAP_EN byte-reverses plaintext into and ciphertext out of the core.
module gcm_block_sequencer #(
  parameter int MAX_AAD_BLKS = 4,
  parameter int MAX_PT_BLKS  = 4,
  parameter int SETUP_HOLD   = 2,
  parameter int SETUP_WAIT   = 40,
  parameter int AAD_GAP      = 12,
  parameter int WATCHDOG     = 1024,
  localparam int AW = $clog2(MAX_AAD_BLKS + 1),
  localparam int PW = $clog2(MAX_PT_BLKS + 1)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [127:0]  i_key,
  input  logic [95:0]   i_iv,
  input  logic [AW-1:0] i_aad_blks,
  input  logic [PW-1:0] i_pt_blks,
  input  logic [127:0]  i_aad,
  input  logic          i_aad_valid,
  output logic          o_aad_ready,
  input  logic [127:0]  i_pt,
  input  logic          i_pt_valid,
  output logic          o_pt_ready,
  output logic [127:0]  o_ct,
  output logic          o_ct_valid,
  input  logic          i_ct_ready,
  output logic [127:0]  o_tag,
  output logic          o_tag_valid,
  input  logic          i_tag_ack,
  output logic          o_busy,
  output logic          o_error,
  output logic          o_core_new_instance,
  output logic          o_core_pt_instance,
  output logic [127:0]  o_core_key,
  output logic [95:0]   o_core_iv,
  output logic [127:0]  o_core_aad,
  output logic [127:0]  o_core_pt,
  output logic [63:0]   o_core_aad_size,
  output logic [63:0]   o_core_pt_size,
  input  logic [127:0]  i_core_ct,
  input  logic          i_core_cp_ready,
  input  logic [127:0]  i_core_tag,
  input  logic          i_core_tag_ready
);

  localparam int TW = $clog2(SETUP_HOLD + SETUP_WAIT + AAD_GAP + WATCHDOG + 1);

  // state    | meaning
  // IDLE     | waiting for a job         SETUP    | new_instance hold, then key/H wait
  // AAD      | accept AAD, gap-paced     PT_ISSUE | accept one plaintext block
  // PT_WAIT  | wait core cp_ready        CT_OUT   | present ciphertext until taken
  // TAG_WAIT | wait core tag_ready       TAG_OUT  | present tag until acknowledged
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_AAD, S_PT_ISSUE, S_PT_WAIT, S_CT_OUT, S_TAG_WAIT, S_TAG_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] aad_left_q, aad_left_d;
  logic [PW-1:0] pt_left_q, pt_left_d;
  logic          err_q, err_d;
  logic          pt_inst_q, pt_inst_d;
  logic [127:0]  key_q, key_d, aad_q, aad_d, pt_q, pt_d, ct_q, ct_d, tag_q, tag_d;
  logic [95:0]   iv_q, iv_d;
  logic [63:0]   aad_sz_q, aad_sz_d, pt_sz_q, pt_sz_d;
  logic          aad_ready, pt_ready;

  function automatic logic [127:0] bswap(input logic [127:0] d);
    logic [127:0] r;
`ifdef GCM_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(15-i) +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    aad_left_d = aad_left_q;
    pt_left_d  = pt_left_q;
    err_d      = 1'b0;
    pt_inst_d  = 1'b0;
    key_d      = key_q;
    iv_d       = iv_q;
    aad_d      = aad_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    tag_d      = tag_q;
    aad_sz_d   = aad_sz_q;
    pt_sz_d    = pt_sz_q;
    aad_ready  = 1'b0;
    pt_ready   = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        if (i_aad_blks <= AW'(MAX_AAD_BLKS) && i_pt_blks <= PW'(MAX_PT_BLKS)) begin
          key_d      = i_key;
          iv_d       = i_iv;
          aad_left_d = i_aad_blks;
          pt_left_d  = i_pt_blks;
          aad_sz_d   = {{(64-AW-7){1'b0}}, i_aad_blks, 7'd0};
          pt_sz_d    = {{(64-PW-7){1'b0}}, i_pt_blks, 7'd0};
          tmr_d      = TW'(SETUP_HOLD + SETUP_WAIT - 1);
          state_d    = S_SETUP;
        end else begin
          err_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (aad_left_q != '0) state_d = S_AAD;
        else if (pt_left_q != '0) state_d = S_PT_ISSUE;
        else begin
          tmr_d   = TW'(WATCHDOG - 1);
          state_d = S_TAG_WAIT;
        end
      end
      S_AAD: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (aad_left_q != '0) begin
          aad_ready = 1'b1;
          if (i_aad_valid) begin
            aad_d      = i_aad;
            tmr_d      = TW'(AAD_GAP);
            aad_left_d = aad_left_q - 1'b1;
          end
        end else if (pt_left_q != '0) state_d = S_PT_ISSUE;
        else begin
          tmr_d   = TW'(WATCHDOG - 1);
          state_d = S_TAG_WAIT;
        end
      end
      S_PT_ISSUE: begin
        pt_ready = 1'b1;
        if (i_pt_valid) begin
          pt_d      = bswap(i_pt);
          pt_inst_d = 1'b1;
          pt_left_d = pt_left_q - 1'b1;
          tmr_d     = TW'(WATCHDOG - 1);
          state_d   = S_PT_WAIT;
        end
      end
      // cp_ready has priority: a concurrent tag_ready here is ignored
      S_PT_WAIT: begin
        if (i_core_cp_ready) begin
          ct_d    = bswap(i_core_ct);
          state_d = S_CT_OUT;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_CT_OUT: if (i_ct_ready) begin
        if (pt_left_q != '0) state_d = S_PT_ISSUE;
        else begin
          tmr_d   = TW'(WATCHDOG - 1);
          state_d = S_TAG_WAIT;
        end
      end
      S_TAG_WAIT: begin
        if (i_core_tag_ready) begin
          tag_d   = i_core_tag;
          state_d = S_TAG_OUT;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_TAG_OUT: if (i_tag_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      aad_left_q <= '0;
      pt_left_q  <= '0;
      err_q      <= 1'b0;
      pt_inst_q  <= 1'b0;
      key_q      <= '0;
      iv_q       <= '0;
      aad_q      <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
      tag_q      <= '0;
      aad_sz_q   <= '0;
      pt_sz_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      aad_left_q <= aad_left_d;
      pt_left_q  <= pt_left_d;
      err_q      <= err_d;
      pt_inst_q  <= pt_inst_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      aad_q      <= aad_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      tag_q      <= tag_d;
      aad_sz_q   <= aad_sz_d;
      pt_sz_q    <= pt_sz_d;
    end
  end

  assign o_aad_ready         = aad_ready;
  assign o_pt_ready          = pt_ready;
  assign o_ct                = ct_q;
  assign o_ct_valid          = (state_q == S_CT_OUT);
  assign o_tag               = tag_q;
  assign o_tag_valid         = (state_q == S_TAG_OUT);
  assign o_busy              = (state_q != S_IDLE);
  assign o_error             = err_q;
  assign o_core_new_instance = (state_q == S_SETUP) && (tmr_q >= TW'(SETUP_WAIT));
  assign o_core_pt_instance  = pt_inst_q;
  assign o_core_key          = key_q;
  assign o_core_iv           = iv_q;
  assign o_core_aad          = aad_q;
  assign o_core_pt           = pt_q;
  assign o_core_aad_size     = aad_sz_q;
  assign o_core_pt_size      = pt_sz_q;

endmodule

// File: tb/tb_gcm_block_sequencer.sv
// Self-checking bench for gcm_block_sequencer with a behavioural stand-in for the gcm_aes core.
module tb_gcm_block_sequencer;
  localparam int H = 2, W = 40, GAP = 12, WD = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst_n, i_start, i_aad_valid, i_pt_valid, i_ct_ready, i_tag_ack;
  logic [127:0] i_key, i_aad, i_pt, i_core_ct, i_core_tag;
  logic [95:0] i_iv;
  logic [2:0] i_aad_blks, i_pt_blks;
  logic i_core_cp_ready, i_core_tag_ready;
  logic o_aad_ready, o_pt_ready, o_ct_valid, o_tag_valid, o_busy, o_error;
  logic o_core_new_instance, o_core_pt_instance;
  logic [127:0] o_ct, o_tag, o_core_key, o_core_aad, o_core_pt;
  logic [95:0] o_core_iv;
  logic [63:0] o_core_aad_size, o_core_pt_size;

  int cmp = 0, err = 0;
  int core_lat = 0;
  bit core_cp_en = 1'b1;

  gcm_block_sequencer dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_key(i_key), .i_iv(i_iv),
    .i_aad_blks(i_aad_blks), .i_pt_blks(i_pt_blks), .i_aad(i_aad), .i_aad_valid(i_aad_valid),
    .o_aad_ready(o_aad_ready), .i_pt(i_pt), .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready),
    .o_ct(o_ct), .o_ct_valid(o_ct_valid), .i_ct_ready(i_ct_ready), .o_tag(o_tag),
    .o_tag_valid(o_tag_valid), .i_tag_ack(i_tag_ack), .o_busy(o_busy), .o_error(o_error),
    .o_core_new_instance(o_core_new_instance), .o_core_pt_instance(o_core_pt_instance),
    .o_core_key(o_core_key), .o_core_iv(o_core_iv), .o_core_aad(o_core_aad), .o_core_pt(o_core_pt),
    .o_core_aad_size(o_core_aad_size), .o_core_pt_size(o_core_pt_size), .i_core_ct(i_core_ct),
    .i_core_cp_ready(i_core_cp_ready), .i_core_tag(i_core_tag), .i_core_tag_ready(i_core_tag_ready)
  );

  wire any_out = |{o_aad_ready, o_pt_ready, o_ct, o_ct_valid, o_tag, o_tag_valid, o_busy, o_error,
                   o_core_new_instance, o_core_pt_instance, o_core_key, o_core_iv, o_core_aad,
                   o_core_pt, o_core_aad_size, o_core_pt_size};

  function automatic logic [127:0] sw(input logic [127:0] d);
    logic [127:0] r;
`ifdef GCM_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(15-i) +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  // Core keystream stand-in; the all-zero key/IV first block is the real AES-GCM value.
  function automatic logic [127:0] ks(input logic [127:0] k, input logic [95:0] v, input int idx);
    if (k == '0 && v == '0 && idx == 0) return 128'h0388dace60b6a392f328c2b971b2fe78;
    return {k[63:0], k[127:64]} ^ {v, 32'(idx) + 32'h9e3779b9};
  endfunction

  function automatic logic [127:0] tag_for(input logic [127:0] k, input logic [95:0] v,
                                           input logic [63:0] a, input logic [63:0] p);
    if (k == '0 && v == '0 && a == '0 && p == 64'd0)   return 128'h58e2fccefa7e3061367f1d57a4e7455a;
    if (k == '0 && v == '0 && a == '0 && p == 64'd128) return 128'hab6e47d42cec13bdf53a67b21257bddf;
    return k ^ {v, 32'h5a5a0f0f} ^ {a, ~p};
  endfunction

  assign i_core_tag_ready = 1'b1;
  assign i_core_tag = tag_for(o_core_key, o_core_iv, o_core_aad_size, o_core_pt_size);

  initial begin : core_model
    int cd, idx;
    bit pend;
    pend = 0; cd = 0; idx = 0;
    i_core_cp_ready = 1'b0;
    i_core_ct = '0;
    forever begin
      @(posedge clk); #1;
      i_core_cp_ready = 1'b0;
      if (!i_rst_n) begin
        pend = 0; idx = 0;
      end else begin
        if (o_core_new_instance) idx = 0;
        if (pend) begin
          if (cd == 0) begin
            i_core_cp_ready = 1'b1;
            i_core_ct = o_core_pt ^ ks(o_core_key, o_core_iv, idx - 1);
            pend = 0;
          end else cd--;
        end
        if (o_core_pt_instance && core_cp_en) begin
          pend = 1; cd = core_lat; idx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [127:0] key, input logic [95:0] iv, input int na, input int np,
                         input bit pt_zero, input int stall_blk, input int stall_cyc, input int lat,
                         output logic [127:0] tag_seen, output logic [127:0] ct0_seen);
    logic [127:0] d, exp_ct, exp_tag;
    int n, hi_first, hi_late, early, stable, lost, dly;
    core_lat = lat;
    ct0_seen = '0;
    i_key = key; i_iv = iv; i_aad_blks = 3'(na); i_pt_blks = 3'(np); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cmp++;
    if ({o_busy, o_core_aad_size, o_core_pt_size, o_core_key, o_core_iv} !==
        {1'b1, 64'(na * 128), 64'(np * 128), key, iv}) begin
      err++;
      $display("FAIL job_latch: busy=%b aad_size=%0d pt_size=%0d expected busy=1 aad_size=%0d pt_size=%0d",
               o_busy, o_core_aad_size, o_core_pt_size, na * 128, np * 128);
    end
    hi_first = 0; hi_late = 0; early = 0;
    for (int i = 0; i < H + W; i++) begin
      if (o_core_new_instance && i < H) hi_first++;
      if (o_core_new_instance && i >= H) hi_late++;
      if (o_aad_ready || o_pt_ready) early++;
      tick();
    end
    cmp++;
    if (hi_first != H || hi_late != 0 || early != 0) begin
      err++;
      $display("FAIL setup_timing: hold=%0d late=%0d early_ready=%0d expected %0d/0/0", hi_first, hi_late, early, H);
    end
    cmp++;
    if ({o_aad_ready, o_pt_ready} !== {1'(na > 0), 1'(na == 0 && np > 0)}) begin
      err++;
      $display("FAIL first_ready: aad_rdy=%b pt_rdy=%b na=%0d np=%0d", o_aad_ready, o_pt_ready, na, np);
    end
    for (int b = 0; b < na; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      i_aad = d; i_aad_valid = 1'b1;
      n = 0;
      while (!o_aad_ready && n < 100) begin tick(); n++; end
      if (n >= 100) begin cmp++; err++; $display("FAIL aad_ready_timeout: block %0d", b); end
      tick();
      i_aad_valid = 1'b0;
      cmp++;
      if (o_core_aad !== d) begin
        err++; $display("FAIL aad_data: got %h expected %h", o_core_aad, d);
      end
      if (b < na - 1) begin
        n = 0;
        while (!o_aad_ready && n < 100) begin tick(); n++; end
        cmp++;
        if (n != GAP) begin err++; $display("FAIL aad_gap: got %0d expected %0d", n, GAP); end
      end
    end
    for (int p = 0; p < np; p++) begin
      d = pt_zero ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
      i_pt = d;
      dly = $urandom_range(0, 2);
      repeat (dly) tick();
      i_pt_valid = 1'b1;
      n = 0;
      while (!o_pt_ready && n < 100) begin tick(); n++; end
      if (n >= 100) begin cmp++; err++; $display("FAIL pt_ready_timeout: block %0d", p); end
      tick();
      i_pt_valid = 1'b0;
      cmp++;
      if ({o_core_pt, o_core_pt_instance, o_pt_ready} !== {sw(d), 1'b1, 1'b0}) begin
        err++;
        $display("FAIL pt_issue: core_pt=%h inst=%b rdy=%b expected %h/1/0", o_core_pt, o_core_pt_instance, o_pt_ready, sw(d));
      end
      n = 0;
      while (!o_ct_valid && n < 100) begin tick(); n++; end
      cmp++;
      if (n != lat + 2) begin err++; $display("FAIL ct_latency: got %0d expected %0d", n, lat + 2); end
      exp_ct = sw(sw(d) ^ ks(key, iv, p));
      cmp++;
      if (o_ct !== exp_ct) begin err++; $display("FAIL ct_data: got %h expected %h", o_ct, exp_ct); end
      if (p == 0) ct0_seen = o_ct;
      if (p == stall_blk) begin
        stable = 0;
        for (int s = 0; s < stall_cyc; s++) begin
          tick();
          if (o_ct_valid && o_ct === exp_ct && !o_pt_ready) stable++;
        end
        cmp++;
        if (stable != stall_cyc) begin
          err++; $display("FAIL ct_backpressure: stable %0d of %0d cycles", stable, stall_cyc);
        end
      end
      i_ct_ready = 1'b1;
      tick();
      i_ct_ready = 1'b0;
      cmp++;
      if (o_ct_valid !== 1'b0) begin err++; $display("FAIL ct_drop: valid=%b expected 0", o_ct_valid); end
    end
    n = 0;
    while (!o_tag_valid && n < 100) begin tick(); n++; end
    exp_tag = tag_for(key, iv, 64'(na * 128), 64'(np * 128));
    cmp++;
    if (o_tag_valid !== 1'b1 || o_tag !== exp_tag) begin
      err++; $display("FAIL tag_data: valid=%b got %h expected %h", o_tag_valid, o_tag, exp_tag);
    end
    tag_seen = o_tag;
    lost = 0;
    dly = $urandom_range(0, 3);
    repeat (dly) begin tick(); if (!o_tag_valid) lost++; end
    i_tag_ack = 1'b1;
    tick();
    i_tag_ack = 1'b0;
    cmp++;
    if (lost != 0 || {o_busy, o_tag_valid, o_tag} !== {1'b0, 1'b0, exp_tag}) begin
      err++;
      $display("FAIL tag_release: lost=%0d busy=%b valid=%b tag=%h expected 0/0/0/%h", lost, o_busy, o_tag_valid, o_tag, exp_tag);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if (any_out !== 1'b0) begin err++; $display("FAIL reset_outputs: any_out=%b expected 0", any_out); end
    @(negedge clk) i_rst_n = 1'b1;
    tick();
    cmp++;
    if (any_out !== 1'b0) begin err++; $display("FAIL post_reset_idle: any_out=%b expected 0", any_out); end
  endtask

  task automatic test_kat_empty();
    logic [127:0] t, c;
    run_job('0, '0, 0, 0, 1'b0, -1, 0, 0, t, c);
    cmp++;
    if (t !== 128'h58e2fccefa7e3061367f1d57a4e7455a) begin
      err++; $display("FAIL kat_empty_tag: got %h expected 58e2fccefa7e3061367f1d57a4e7455a", t);
    end
  endtask

  task automatic test_kat_one_block();
    logic [127:0] t, c, kat;
    kat = 128'h0388dace60b6a392f328c2b971b2fe78;
    run_job('0, '0, 0, 1, 1'b1, -1, 0, 2, t, c);
    cmp++;
    if (c !== sw(kat) || t !== 128'hab6e47d42cec13bdf53a67b21257bddf) begin
      err++; $display("FAIL kat_one_block: ct=%h tag=%h expected %h / ab6e47d42cec13bdf53a67b21257bddf", c, t, sw(kat));
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] t, c;
    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 3, 4, 1'b0, 2, 10, 1, t, c);
  endtask

  task automatic test_reject();
    for (int k = 0; k < 2; k++) begin
      i_aad_blks = (k == 0) ? 3'd1 : 3'd5;
      i_pt_blks  = (k == 0) ? 3'd5 : 3'd1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      cmp++;
      if ({o_error, o_busy} !== 2'b10) begin
        err++; $display("FAIL reject_pulse: error=%b busy=%b expected 1/0", o_error, o_busy);
      end
      tick();
      cmp++;
      if ({o_error, o_busy} !== 2'b00) begin
        err++; $display("FAIL reject_single: error=%b busy=%b expected 0/0", o_error, o_busy);
      end
    end
  endtask

  task automatic test_watchdog();
    int n;
    core_cp_en = 1'b0;
    i_key = {4{$urandom}}; i_iv = {3{$urandom}}; i_aad_blks = 3'd0; i_pt_blks = 3'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_pt = {4{$urandom}};
    n = 0;
    while (!o_pt_ready && n < 100) begin tick(); n++; end
    i_pt_valid = 1'b1;
    tick();
    i_pt_valid = 1'b0;
    n = 0;
    while (!o_error && n < WD + 50) begin tick(); n++; end
    cmp++;
    if (n != WD || {o_busy, o_ct_valid, o_tag_valid} !== 3'b000) begin
      err++;
      $display("FAIL watchdog: cycles=%0d busy=%b ct_v=%b tag_v=%b expected %0d/0/0/0", n, o_busy, o_ct_valid, o_tag_valid, WD);
    end
    tick();
    cmp++;
    if (o_error !== 1'b0) begin err++; $display("FAIL watchdog_pulse: error=%b expected 0", o_error); end
    core_cp_en = 1'b1;
  endtask

  task automatic test_reset_mid_job();
    int n;
    logic [127:0] t, c;
    core_lat = 1;
    i_key = {4{$urandom}}; i_iv = {3{$urandom}}; i_aad_blks = 3'd0; i_pt_blks = 3'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_pt = {4{$urandom}}; i_pt_valid = 1'b1;
    n = 0;
    while (!o_ct_valid && n < 200) begin tick(); n++; end
    if (n >= 200) begin cmp++; err++; $display("FAIL mid_reset_reach_ct: timeout"); end
    #2 i_rst_n = 1'b0;
    #1;
    cmp++;
    if (any_out !== 1'b0) begin err++; $display("FAIL async_reset: any_out=%b expected 0", any_out); end
    i_pt_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) i_rst_n = 1'b1;
    tick();
    run_job({4{$urandom}}, {3{$urandom}}, 1, 2, 1'b0, 0, 3, 0, t, c);
  endtask

  task automatic test_random();
    logic [127:0] t, c;
    for (int j = 0; j < 6; j++)
      run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
              $urandom_range(0, 4), $urandom_range(0, 4), 1'b0,
              $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 4), t, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_aad_valid = 1'b0; i_pt_valid = 1'b0;
    i_ct_ready = 1'b0; i_tag_ack = 1'b0; i_key = '0; i_iv = '0; i_aad = '0; i_pt = '0;
    i_aad_blks = '0; i_pt_blks = '0;
    test_reset();
    test_kat_empty();
    test_kat_one_block();
    test_backpressure();
    test_reject();
    test_watchdog();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
